memory_stage: RTL and testbench

// - MEM stage of the 5-stage RV32I pipeline; consumes the EXE/MEM registers and produces MEM/WB registers.
// - Runs loads/stores on a req/ack data bus through an IDLE/BUSY FSM, with stall, timeout and misalignment handling.
// - Drives forward_mem back to execute and stalls upstream stages while an access is outstanding.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/lsu_align.sv | 54 +++++
 rtl/memory_stage.sv | 167 ++++++++++++++++
 tb/tb_memory_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory stage: opcodes, funct3 codes,
// the load/store FSM state type and the alignment rule.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // funct3 access-width codes (stores reuse the B/H/W encodings)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mem_state_t;

  // Halfwords need addr[0]==0; words (and reserved widths) need addr[1:0]==0.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: replicates store data across lanes with
// matching byte enables, and shifts/extends the read word for loads.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_word,
  output logic [XLEN-1:0] lane_data,
  output logic [3:0]      byte_en,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0]   shifted;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  // Store lanes: bytes and halves are replicated so any enabled lane is correct
  always_comb begin
    lane_data = store_data;
    byte_en   = 4'hF;
    case (funct3[1:0])
      2'b00: begin
        lane_data = {4{store_data[7:0]}};
        byte_en   = 4'b0001 << addr_lo;
      end
      2'b01: begin
        lane_data = {2{store_data[15:0]}};
        byte_en   = 4'b0011 << {addr_lo[1], 1'b0};
      end
      default: begin
        lane_data = store_data;
        byte_en   = 4'hF;
      end
    endcase
  end

  // Load path: bring the addressed byte/half down to bit 0, then extend
  always_comb begin
    shifted   = load_word >> {addr_lo, 3'b000};
    byte_s    = shifted[7:0];
    half_s    = shifted[15:0];
    load_data = shifted;
    case (funct3)
      F3_LB:   load_data = XLEN'(byte_s);
      F3_LH:   load_data = XLEN'(half_s);
      F3_LBU:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_LHU:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// RV32I MEM stage: issues loads/stores on a req/ack bus via an IDLE/BUSY FSM,
// stalls upstream while an access is outstanding, aborts on timeout, drops
// misaligned accesses, and fills the MEM/WB registers.
module memory_stage
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_mem,
  input  logic [XLEN-1:0] pc_mem,
  input  logic [XLEN-1:0] alu_mem,
  input  logic [XLEN-1:0] rs2_mem,
  input  logic [XLEN-1:0] instr_mem,
  input  logic [4:0]      rd_addr_mem,
  output logic [XLEN-1:0] forward_mem,
  output logic            stall_mem,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] pc_wb,
  output logic [XLEN-1:0] alu_wb,
  output logic [XLEN-1:0] instr_wb,
  output logic [XLEN-1:0] mem_data_wb,
  output logic [4:0]      rd_addr_wb,
  output logic            valid_wb,
  output logic            misaligned,
  output logic            bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  mem_state_t        state;
  logic [CNT_W-1:0]  count;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              is_load;
  logic              is_store;
  logic              mem_op;
  logic              mis_c;
  logic              idle;
  logic              busy;
  logic              start;
  logic              timeout_hit;
  logic              finish_ack;
  logic              abort;
  logic [XLEN-1:0]   lane_data;
  logic [3:0]        byte_en;
  logic [XLEN-1:0]   load_data;

  assign opcode      = instr_mem[6:0];
  assign funct3      = instr_mem[14:12];
  assign is_load     = (opcode == OPC_LOAD);
  assign is_store    = (opcode == OPC_STORE);
  assign mem_op      = valid_mem & (is_load | is_store);
  assign idle        = (state == IDLE);
  assign busy        = (state == BUSY);
  assign mis_c       = idle & mem_op & is_misaligned(funct3, alu_mem[1:0]);
  assign start       = idle & mem_op & ~mis_c;
  assign timeout_hit = busy & (count == CNT_W'(TIMEOUT - 1));
  assign finish_ack  = busy & dmem_ack;
  // An ack arriving on the last allowed cycle still completes the access.
  assign abort       = timeout_hit & ~dmem_ack;

  assign forward_mem = alu_mem;
  assign misaligned  = mis_c;
  assign bus_err     = abort;
  // Stall is forced low while in reset so upstream stages are not frozen.
  assign stall_mem   = rst_n & (start | (busy & ~dmem_ack & ~timeout_hit));

  lsu_align u_align (
    .funct3     (funct3),
    .addr_lo    (alu_mem[1:0]),
    .store_data (rs2_mem),
    .load_word  (dmem_rdata),
    .lane_data  (lane_data),
    .byte_en    (byte_en),
    .load_data  (load_data)
  );

  // FSM and BUSY-cycle timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (start) state <= BUSY;
        end
        BUSY: begin
          if (finish_ack || timeout_hit) begin
            state <= IDLE;
            count <= '0;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // Bus request registers: captured on issue, held through BUSY, cleared on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= 4'h0;
    end else if (start) begin
      dmem_req   <= 1'b1;
      dmem_we    <= is_store;
      dmem_addr  <= {alu_mem[XLEN-1:2], 2'b00};
      dmem_wdata <= lane_data;
      dmem_be    <= byte_en;
    end else if (finish_ack || timeout_hit) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= 4'h0;
    end
  end

  // MEM/WB registers: pass-through when idle, result on ack, bubble otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_wb       <= '0;
      alu_wb      <= '0;
      instr_wb    <= '0;
      mem_data_wb <= '0;
      rd_addr_wb  <= 5'd0;
      valid_wb    <= 1'b0;
    end else if (idle && !start) begin
      pc_wb       <= pc_mem;
      alu_wb      <= alu_mem;
      instr_wb    <= instr_mem;
      mem_data_wb <= load_data;
      valid_wb    <= valid_mem & ~mis_c;
      rd_addr_wb  <= (valid_mem && !mis_c && !is_store) ? rd_addr_mem : 5'd0;
    end else if (finish_ack) begin
      pc_wb       <= pc_mem;
      alu_wb      <= alu_mem;
      instr_wb    <= instr_mem;
      mem_data_wb <= load_data;
      valid_wb    <= 1'b1;
      rd_addr_wb  <= is_store ? 5'd0 : rd_addr_mem;
    end else begin
      valid_wb    <= 1'b0;
      rd_addr_wb  <= 5'd0;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: table of load/store/ALU vectors driven one at a time
// with a bus responder, MEM/WB results checked through a scoreboard queue,
// plus hand-written reset sequences.
module tb_memory_stage;
  import riscv_pkg::*;

  localparam int TO    = 4;
  localparam int NOACK = -1;
  localparam logic [6:0] OPC_ALUI = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_mem;
  logic [31:0] pc_mem, alu_mem, rs2_mem, instr_mem;
  logic [4:0]  rd_addr_mem;
  logic [31:0] forward_mem;
  logic        stall_mem, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] pc_wb, alu_wb, instr_wb, mem_data_wb;
  logic [4:0]  rd_addr_wb;
  logic        valid_wb, misaligned, bus_err;

  always #5 clk = ~clk;

  memory_stage #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_mem   (valid_mem),
    .pc_mem      (pc_mem),
    .alu_mem     (alu_mem),
    .rs2_mem     (rs2_mem),
    .instr_mem   (instr_mem),
    .rd_addr_mem (rd_addr_mem),
    .forward_mem (forward_mem),
    .stall_mem   (stall_mem),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_be     (dmem_be),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata),
    .pc_wb       (pc_wb),
    .alu_wb      (alu_wb),
    .instr_wb    (instr_wb),
    .mem_data_wb (mem_data_wb),
    .rd_addr_wb  (rd_addr_wb),
    .valid_wb    (valid_wb),
    .misaligned  (misaligned),
    .bus_err     (bus_err)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          ack_dly;
    bit          exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
    bit          chk_data;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] data;
    logic [4:0]  rd;
    bit          chk_data;
  } wb_t;

  wb_t  sbq[$];
  vec_t vecs[14];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mkinstr(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] rd);
    return {17'b0, f3, rd, op};
  endfunction

  // Scoreboard: every valid MEM/WB slot must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid_wb === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected actual pc=%h required no valid slot", pc_wb);
      end else begin
        wb_t e;
        e = sbq.pop_front();
        check("wb_pc", pc_wb, e.pc);
        check("wb_alu", alu_wb, e.alu);
        check("wb_rd", 32'(rd_addr_wb), 32'(e.rd));
        if (e.chk_data) check("wb_data", mem_data_wb, e.data);
      end
    end
  end

  // Drives one vector starting on a negedge; returns on a later negedge
  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] pc;
    logic [4:0]  rd;
    bit          mem, st, will_wb, done;
    wb_t         e;
    pc      = 32'h1000 + 32'(idx * 4);
    rd      = 5'(idx + 1);
    mem     = (v.op == OPC_LOAD) || (v.op == OPC_STORE);
    st      = (v.op == OPC_STORE);
    will_wb = !v.exp_mis && (!mem || (v.ack_dly >= 0 && v.ack_dly < TO));
    valid_mem   = 1'b1;
    pc_mem      = pc;
    alu_mem     = v.addr;
    rs2_mem     = v.rs2;
    instr_mem   = mkinstr(v.op, v.f3, rd);
    rd_addr_mem = rd;
    dmem_rdata  = v.rdata;
    if (will_wb) begin
      e.pc = pc; e.alu = v.addr; e.data = v.exp_data;
      e.rd = st ? 5'd0 : rd; e.chk_data = v.chk_data;
      sbq.push_back(e);
    end
    #1;
    check("forward", forward_mem, v.addr);
    check("misaligned", 32'(misaligned), 32'(v.exp_mis));
    check("stall_issue", 32'(stall_mem), 32'(mem && !v.exp_mis));
    if (!mem || v.exp_mis) begin
      @(negedge clk);
      check("req_idle", 32'(dmem_req), 32'd0);
      if (v.exp_mis) check("mis_bubble", 32'(valid_wb), 32'd0);
    end else begin
      done = 1'b0;
      for (int k = 1; k <= 3 * TO && !done; k++) begin
        @(negedge clk);
        check("req_held", 32'(dmem_req), 32'd1);
        if (k == 1) begin
          check("bus_addr", dmem_addr, {v.addr[31:2], 2'b00});
          check("bus_be", 32'(dmem_be), 32'(v.exp_be));
          check("bus_we", 32'(dmem_we), 32'(st));
          if (st) check("bus_wdata", dmem_wdata, v.exp_wdata);
        end
        if (k - 1 == v.ack_dly) begin
          dmem_ack = 1'b1;
          #1;
          check("stall_ack", 32'(stall_mem), 32'd0);
          check("bus_err_ack", 32'(bus_err), 32'd0);
          done = 1'b1;
        end else begin
          #1;
          check("bus_err", 32'(bus_err), 32'(k == TO));
          check("stall_busy", 32'(stall_mem), 32'(k != TO));
          if (k == TO) done = 1'b1;
        end
      end
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL busy_budget actual=still busy required=ack or timeout by cycle %0d", TO);
      end
      @(negedge clk);
      dmem_ack = 1'b0;
      check("req_release", 32'(dmem_req), 32'd0);
      if (v.ack_dly < 0) check("timeout_bubble", 32'(valid_wb), 32'd0);
    end
    valid_mem = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{OPC_STORE, F3_LW,  32'h100, 32'hDEADBEEF, 32'h0,        0,     1'b0, 4'hF,    32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{OPC_LOAD,  F3_LB,  32'h103, 32'h0,        32'h80FFFF00, 0,     1'b0, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b1};
    vecs[2]  = '{OPC_LOAD,  F3_LBU, 32'h103, 32'h0,        32'h80FFFF00, 0,     1'b0, 4'b1000, 32'h0,        32'h00000080, 1'b1};
    vecs[3]  = '{OPC_STORE, F3_LH,  32'h102, 32'h1234ABCD, 32'h0,        1,     1'b0, 4'b1100, 32'hABCDABCD, 32'h0,        1'b0};
    vecs[4]  = '{OPC_LOAD,  F3_LW,  32'h101, 32'h0,        32'h0,        0,     1'b1, 4'h0,    32'h0,        32'h0,        1'b0};
    vecs[5]  = '{OPC_LOAD,  F3_LH,  32'h102, 32'h0,        32'h80011234, 2,     1'b0, 4'b1100, 32'h0,        32'hFFFF8001, 1'b1};
    vecs[6]  = '{OPC_LOAD,  F3_LHU, 32'h102, 32'h0,        32'h80011234, 0,     1'b0, 4'b1100, 32'h0,        32'h00008001, 1'b1};
    vecs[7]  = '{OPC_LOAD,  F3_LW,  32'h200, 32'h0,        32'h12345678, 3,     1'b0, 4'hF,    32'h0,        32'h12345678, 1'b1};
    vecs[8]  = '{OPC_LOAD,  F3_LW,  32'h204, 32'h0,        32'h0,        NOACK, 1'b0, 4'hF,    32'h0,        32'h0,        1'b0};
    vecs[9]  = '{OPC_ALUI,  3'b000, 32'h55,  32'h0,        32'h0,        0,     1'b0, 4'h0,    32'h0,        32'h0,        1'b0};
    vecs[10] = '{OPC_STORE, F3_LB,  32'h101, 32'h000000A5, 32'h0,        0,     1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[11] = '{OPC_LOAD,  F3_LH,  32'h101, 32'h0,        32'h0,        0,     1'b1, 4'h0,    32'h0,        32'h0,        1'b0};
    vecs[12] = '{OPC_LOAD,  F3_LB,  32'h100, 32'h0,        32'h0000007F, 1,     1'b0, 4'b0001, 32'h0,        32'h0000007F, 1'b1};
    vecs[13] = '{OPC_LOAD,  F3_LW,  32'h210, 32'h0,        32'hCAFEBABE, 0,     1'b0, 4'hF,    32'h0,        32'hCAFEBABE, 1'b1};

    // Reset with an aligned load presented: nothing may leave the stage
    rst_n       = 1'b0;
    valid_mem   = 1'b1;
    pc_mem      = 32'h40;
    alu_mem     = 32'h100;
    rs2_mem     = 32'h0;
    instr_mem   = mkinstr(OPC_LOAD, F3_LW, 5'd3);
    rd_addr_mem = 5'd3;
    dmem_ack    = 1'b0;
    dmem_rdata  = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_stall", 32'(stall_mem), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_valid_wb", 32'(valid_wb), 32'd0);
    check("rst_pc_wb", pc_wb, 32'd0);
    check("rst_data_wb", mem_data_wb, 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    valid_mem = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Reset while BUSY: request and stall drop at once, a late ack is ignored
    valid_mem   = 1'b1;
    pc_mem      = 32'h2000;
    alu_mem     = 32'h300;
    instr_mem   = mkinstr(OPC_LOAD, F3_LW, 5'd9);
    rd_addr_mem = 5'd9;
    @(negedge clk);
    check("pre_rst_req", 32'(dmem_req), 32'd1);
    check("pre_rst_stall", 32'(stall_mem), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(dmem_req), 32'd0);
    check("mid_rst_stall", 32'(stall_mem), 32'd0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h11112222;
    @(negedge clk);
    rst_n     = 1'b1;
    valid_mem = 1'b0;
    @(negedge clk);
    check("late_ack_valid", 32'(valid_wb), 32'd0);
    check("late_ack_req", 32'(dmem_req), 32'd0);
    check("late_ack_stall", 32'(stall_mem), 32'd0);
    dmem_ack = 1'b0;

    // FSM must be back in IDLE and serve a fresh access normally
    run_vec(vecs[13], 20);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
